// File: rtl/rule_port_filter_if.sv
// rule_port_filter_if: rule stream in, result stream out, table config port and event counters
//   master (upstream/config/downstream side): drives in_*, cfg_*, out_ready
//   slave  (filter side): drives in_ready, out_valid, out_rule, out_match, match_cnt, drop_cnt
//   cfg_wdata is wide enough for either a rule2pg row or a 36-bit pg entry, LSB-aligned
interface rule_port_filter_if #(
  parameter int RULE_AWIDTH = 16,
  parameter int PG_AWIDTH = 9,
  parameter int NUM_PG = 4
);
  localparam int CFG_W = (NUM_PG * PG_AWIDTH > 36) ? NUM_PG * PG_AWIDTH : 36;
  logic in_valid;
  logic in_ready;
  logic [RULE_AWIDTH-1:0] in_rule;
  logic [15:0] in_src_port;
  logic [15:0] in_dst_port;
  logic in_tcp;
  logic out_valid;
  logic out_ready;
  logic [RULE_AWIDTH-1:0] out_rule;
  logic out_match;
  logic cfg_we;
  logic cfg_sel;
  logic [RULE_AWIDTH-1:0] cfg_addr;
  logic [CFG_W-1:0] cfg_wdata;
  logic [31:0] match_cnt;
  logic [31:0] drop_cnt;
  modport master (
    output in_valid, in_rule, in_src_port, in_dst_port, in_tcp, out_ready,
    output cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    input in_ready, out_valid, out_rule, out_match, match_cnt, drop_cnt
  );
  modport slave (
    input in_valid, in_rule, in_src_port, in_dst_port, in_tcp, out_ready,
    input cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    output in_ready, out_valid, out_rule, out_match, match_cnt, drop_cnt
  );
endinterface

// File: rtl/rule_port_filter.sv
// rule_port_filter: 4-stage rule-to-port-group filter matching L4 ports against per-rule group tables
//   clk, rst : clock, synchronous active-high reset
//   bus      : rule_port_filter_if.slave (input stream, output stream, table config, counters)
//   rule2pg row = NUM_PG fields of PG_AWIDTH bits, field k at [k*PG_AWIDTH +: PG_AWIDTH], addressed by rule-1
//   pg entry = {mode[35:34], dir[33], tcp[32], lo[31:16], hi[15:0]}, addressed by pg-1
//   cfg_addr is the raw table index; pg writes with address bits above PG_AWIDTH set are ignored
module rule_port_filter #(
  parameter int RULE_AWIDTH = 16,
  parameter int PG_AWIDTH = 9,
  parameter int NUM_PG = 4,
  parameter bit PASS_ALL = 1'b0
) (
  input logic clk,
  input logic rst,
  rule_port_filter_if.slave bus
);
  localparam int R2PG_W = NUM_PG * PG_AWIDTH;
  logic [R2PG_W-1:0] r_r2pg_mem [2**RULE_AWIDTH];
  logic [35:0] r_pg_mem [2**PG_AWIDTH];
  logic w_adv;
  logic w_emit;
  logic w_drop;
  logic w_pg_wr;
  logic [RULE_AWIDTH-1:0] w_ridx;
  logic [NUM_PG-1:0] w_hit;
  logic r_s1_v, r_s2_v, r_s3_v;
  logic [RULE_AWIDTH-1:0] r_s1_rule, r_s2_rule, r_s3_rule;
  logic [15:0] r_s1_src, r_s1_dst, r_s2_src, r_s2_dst;
  logic r_s1_tcp, r_s2_tcp;
  logic [R2PG_W-1:0] r_s1_fields;
  logic r_s3_match;
  logic r_out_v;
  logic r_out_match;
  logic [RULE_AWIDTH-1:0] r_out_rule;
  logic [31:0] r_match_cnt, r_drop_cnt;
  // every stage moves together; a held output freezes the whole pipe, table reads included
  assign w_adv = !r_out_v || bus.out_ready;
  assign w_ridx = bus.in_rule - RULE_AWIDTH'(1);
  assign w_pg_wr = bus.cfg_we && bus.cfg_sel && ((bus.cfg_addr >> PG_AWIDTH) == '0);
  assign w_emit = r_s3_v && (r_s3_rule != '0) && (PASS_ALL || r_s3_match);
  assign w_drop = w_adv && r_s3_v && !w_emit;
  assign bus.in_ready = w_adv;
  assign bus.out_valid = r_out_v;
  assign bus.out_rule = r_out_rule;
  assign bus.out_match = r_out_match;
  assign bus.match_cnt = r_match_cnt;
  assign bus.drop_cnt = r_drop_cnt;
  // writes land at the edge, so a same-cycle read of that address sees the old entry
  always_ff @(posedge clk) begin
    if (bus.cfg_we && !bus.cfg_sel) r_r2pg_mem[bus.cfg_addr] <= bus.cfg_wdata[R2PG_W-1:0];
    if (w_pg_wr) r_pg_mem[bus.cfg_addr[PG_AWIDTH-1:0]] <= bus.cfg_wdata[35:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_s3_v <= 1'b0;
      r_out_v <= 1'b0;
      r_out_match <= 1'b0;
      r_out_rule <= '0;
    end else if (w_adv) begin
      r_s1_v <= bus.in_valid;
      r_s2_v <= r_s1_v;
      r_s3_v <= r_s2_v;
      r_out_v <= w_emit;
      r_out_match <= r_s3_match;
      r_out_rule <= r_s3_rule;
    end
  end
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s1_rule <= bus.in_rule;
      r_s1_src <= bus.in_src_port;
      r_s1_dst <= bus.in_dst_port;
      r_s1_tcp <= bus.in_tcp;
      r_s1_fields <= r_r2pg_mem[w_ridx];
      r_s2_rule <= r_s1_rule;
      r_s2_src <= r_s1_src;
      r_s2_dst <= r_s1_dst;
      r_s2_tcp <= r_s1_tcp;
      r_s3_rule <= r_s2_rule;
      r_s3_match <= |w_hit;
    end
  end
  for (genvar g = 0; g < NUM_PG; g++) begin : g_pg
    logic [PG_AWIDTH-1:0] w_f;
    logic [15:0] w_port;
    logic [1:0] w_mode;
    logic [35:0] r_pg;
    logic r_used;
    assign w_f = r_s1_fields[g*PG_AWIDTH +: PG_AWIDTH];
    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_pg <= r_pg_mem[w_f - PG_AWIDTH'(1)];
        r_used <= |w_f;
      end
    end
    assign w_mode = r_pg[35:34];
    assign w_port = r_pg[33] ? r_s2_dst : r_s2_src;
    assign w_hit[g] = r_used && (w_mode != 2'd0) && (r_pg[32] == r_s2_tcp) &&
                      ((w_mode == 2'd1) ||
                       ((w_mode == 2'd2) ? (w_port == r_pg[31:16])
                                         : (w_port >= r_pg[31:16] && w_port <= r_pg[15:0])));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_match_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (r_out_v && bus.out_ready && r_out_match && !(&r_match_cnt)) r_match_cnt <= r_match_cnt + 32'd1;
      if (w_drop && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end
endmodule
